// File: rtl/agen_lsu_pipe_if.sv
// Handshake bundle between AGEN (master side) and the AGEN->LSU register pipe (slave side).
interface agen_lsu_pipe_if #(
  parameter int LANES = 2,
  parameter int PKT_W = 96
);
  logic                   flush_i;
  logic [LANES-1:0]       valid_i;
  logic [LANES*PKT_W-1:0] pkt_i;
  logic                   ready_o;
  logic [LANES-1:0]       valid_o;
  logic [LANES*PKT_W-1:0] pkt_o;
  logic                   ready_i;
  logic [2:0]             occ_o;

  modport master (
    output flush_i, valid_i, pkt_i, ready_i,
    input  ready_o, valid_o, pkt_o, occ_o
  );

  modport slave (
    input  flush_i, valid_i, pkt_i, ready_i,
    output ready_o, valid_o, pkt_o, occ_o
  );
endinterface

// File: rtl/agen_lsu_pipe.sv
// Elastic, bubble-collapsing register pipe carrying memPkt groups from AGEN to LSU.
// Optional macro AGEN_LSU_PIPE_SCRUB_EN zeroes the payload of every invalid lane.
module agen_lsu_pipe #(
  parameter int LANES = 2,
  parameter int DEPTH = 2,
  parameter int PKT_W = 96
) (
  input  logic          clk,
  input  logic          reset,
  agen_lsu_pipe_if.slave bus
);
  localparam int PW = LANES * PKT_W;

  logic [LANES-1:0] vld_reg  [DEPTH];
  logic [LANES-1:0] vld_next [DEPTH];
  logic [PW-1:0]    pkt_reg  [DEPTH];
  logic [PW-1:0]    pkt_next [DEPTH];
  logic [LANES-1:0] src_vld  [DEPTH];
  logic [PW-1:0]    src_pkt  [DEPTH];

  logic [DEPTH-1:0] occ;
  logic [DEPTH-1:0] empty;
  logic [DEPTH-1:0] move;
  logic [DEPTH-1:0] load;
  logic [2:0]       occ_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      // A stage can move on when any stage downstream of it is empty or the LSU takes the
      // last stage; evaluated flat so there is no combinational chain between stages.
      localparam int START = (gi == DEPTH - 1) ? gi : gi + 1;

      assign occ[gi]   = |vld_reg[gi];
      assign empty[gi] = ~occ[gi];
      assign move[gi]  = bus.ready_i | (|(empty >> START));

      if (gi == 0) begin : g_head
        assign src_vld[gi] = bus.valid_i;
        assign src_pkt[gi] = bus.pkt_i;
        assign load[gi]    = bus.ready_o;
      end else begin : g_body
        assign src_vld[gi] = vld_reg[gi-1];
        assign src_pkt[gi] = pkt_reg[gi-1];
        assign load[gi]    = move[gi-1];
      end
    end
  endgenerate

  assign bus.ready_o = empty[0] | move[0];

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      vld_next[k] = vld_reg[k];
      pkt_next[k] = pkt_reg[k];
      if (bus.flush_i) begin
        vld_next[k] = '0;
      end else if (load[k]) begin
        vld_next[k] = src_vld[k];
        // Only lanes carrying a valid packet are written; stale lanes keep their old payload.
        for (int l = 0; l < LANES; l++) begin
          if (src_vld[k][l]) begin
            pkt_next[k][l*PKT_W +: PKT_W] = src_pkt[k][l*PKT_W +: PKT_W];
          end
        end
      end
`ifdef AGEN_LSU_PIPE_SCRUB_EN
      for (int l = 0; l < LANES; l++) begin
        if (!vld_next[k][l]) begin
          pkt_next[k][l*PKT_W +: PKT_W] = '0;
        end
      end
`else
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        vld_reg[k] <= '0;
        pkt_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        vld_reg[k] <= vld_next[k];
        pkt_reg[k] <= pkt_next[k];
      end
    end
  end

  always_comb begin
    occ_cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_cnt = occ_cnt + {2'b00, occ[k]};
    end
  end

  assign bus.occ_o   = occ_cnt;
  assign bus.valid_o = vld_reg[DEPTH-1];
  assign bus.pkt_o   = pkt_reg[DEPTH-1];
endmodule
